// File: rtl/seq_divider.sv
// seq_divider
//   Sequential radix-2 restoring divider. A start pulse in IDLE loads the
//   operand pair; one quotient bit is produced per clock, and a one-cycle
//   done pulse marks valid results. Results are held until the next
//   accepted start.
//
//   Build option: define DIV_SIGNED_EN for two's-complement operands and
//   results. The quotient truncates toward zero and the remainder takes the
//   sign of the dividend. Without the macro the divider is purely unsigned.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset
//     start        request, sampled only in IDLE
//     dividend     numerator, sampled on the accepting edge
//     divisor      denominator, sampled on the accepting edge
//     busy         high while iterating
//     done         one-cycle pulse, results valid
//     quotient     result quotient
//     remainder    result remainder
//     div_by_zero  sampled divisor was zero; held with the results
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one subtract-and-restore step per clock, WIDTH steps
//   DONE  | results valid, done pulse, back to IDLE next edge
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_iter;
    logic             dvs_zero;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             trial_neg;
    logic [WIDTH:0]   prem_nxt;
    logic [WIDTH-1:0] dq_nxt;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign dvs_zero  = (divisor == '0);
    assign accept    = (state == ST_IDLE) && start;
    assign last_iter = (state == ST_RUN) && (cnt == CNT_W'(1));

    // dq starts as the dividend and fills with quotient bits from the right,
    // so after WIDTH steps it holds the quotient. One extra top bit on the
    // trial difference acts as the borrow that decides restore vs keep.
    assign shifted   = {prem, dq[WIDTH-1]};
    assign trial     = shifted - {2'b00, dvs};
    assign trial_neg = trial[WIDTH+1];
    assign prem_nxt  = trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    assign dq_nxt    = {dq[WIDTH-2:0], ~trial_neg};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // The magnitude of the most-negative value still fits as an unsigned
    // WIDTH-bit number, so the core needs no extra bit for it.
    assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign q_fix = neg_q ? -dq_nxt : dq_nxt;
    assign r_fix = neg_r ? -prem_nxt[WIDTH-1:0] : prem_nxt[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept && !dvs_zero) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign mag_a = dividend;
    assign mag_b = divisor;
    assign q_fix = dq_nxt;
    assign r_fix = prem_nxt[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = dvs_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prem <= '0;
            dq   <= '0;
            dvs  <= '0;
            cnt  <= '0;
        end else if (accept && !dvs_zero) begin
            prem <= '0;
            dq   <= mag_a;
            dvs  <= mag_b;
            cnt  <= CNT_W'(WIDTH);
        end else if (state == ST_RUN) begin
            prem <= prem_nxt;
            dq   <= dq_nxt;
            cnt  <= cnt - CNT_W'(1);
        end
    end

    // Results are written on the edge that enters DONE: either directly at
    // accept for a zero divisor, or with the final step's values.
    always_ff @(posedge clk) begin
        if (rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (dvs_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                div_by_zero <= 1'b0;
            end
        end else if (last_iter) begin
            quotient  <= q_fix;
            remainder <= r_fix;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference division straight from the arithmetic definition.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        int sa, sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
`else
            sa = int'({24'd0, a});
            sb = int'({24'd0, b});
`endif
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    // Behavioural model: tracks, per edge number, when the divider is free,
    // which cycles are busy, which cycle shows done, and the held results.
    int           ecount    = 0;
    int           free_at   = 0;
    int           busy_from = -1;
    int           busy_to   = -2;
    int           done_cyc  = -1;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic         m_dbz = 1'b0, p_dbz = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            ecount++;
            if (rst) begin
                m_q       = '0;
                m_r       = '0;
                m_dbz     = 1'b0;
                busy_from = -1;
                busy_to   = -2;
                done_cyc  = -1;
                free_at   = ecount + 1;
            end else begin
                if (start && ecount >= free_at) begin
                    ref_div(dividend, divisor, p_q, p_r, p_dbz);
                    m_dbz = 1'b0;
                    if (divisor == '0) begin
                        busy_from = -1;
                        busy_to   = -2;
                        done_cyc  = ecount;
                    end else begin
                        busy_from = ecount;
                        busy_to   = ecount + W - 1;
                        done_cyc  = ecount + W;
                    end
                    free_at = done_cyc + 2;
                end
                if (ecount == done_cyc) begin
                    m_q   = p_q;
                    m_r   = p_r;
                    m_dbz = p_dbz;
                end
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_busy", 32'(busy), 32'(ecount >= busy_from && ecount <= busy_to));
            chk("cyc_done", 32'(done), 32'(ecount == done_cyc));
            chk("cyc_quotient", 32'(quotient), 32'(m_q));
            chk("cyc_remainder", 32'(remainder), 32'(m_r));
            chk("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
        end
    end

    task automatic wait_done(input int e0, output int off, output int nb);
        off = -1;
        nb  = 0;
        for (int i = 0; i < 4 * W + 8; i++) begin
            if (done) begin
                off = ecount - e0;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
        if (off < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done at t=%0t", $time);
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int eoff, input int ebusy);
        int e0, off, nb;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e0       = ecount + 1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e0, off, nb);
        chk({tag, "_offset"}, off, eoff);
        chk({tag, "_busy_cycles"}, nb, ebusy);
        chk({tag, "_q"}, 32'(quotient), 32'(eq));
        chk({tag, "_r"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        @(negedge clk);
    endtask

    initial begin
        int e0, off, nb, ndone;
        logic [W-1:0] tq, tr;
        logic         tdz;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // Pin the model with hand-computed values.
        ref_div(8'd100, 8'd3, tq, tr, tdz);
        chk("model_100_3_q", 32'(tq), 32'd33);
        chk("model_100_3_r", 32'(tr), 32'd1);
        ref_div(8'd5, 8'd0, tq, tr, tdz);
        chk("model_5_0", 32'({tdz, tq, tr}), 32'h1FF05);

`ifdef DIV_SIGNED_EN
        do_op("d200_7", 8'd200, 8'd7, 8'hF8, 8'd0, 1'b0, W, W);
`else
        do_op("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, W, W);
`endif
        do_op("d255_1", 8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, W, W);
        do_op("d3_250", 8'd3, 8'd250, 8'd0, 8'd3, 1'b0, W, W);
        do_op("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0, W, W);
        do_op("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 0, 0);
`ifdef DIV_SIGNED_EN
        do_op("sm7_2", 8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, W, W);
        do_op("s7_m2", 8'd7, 8'hFE, 8'hFD, 8'd1, 1'b0, W, W);
        do_op("sm128_m1", 8'h80, 8'hFF, 8'h80, 8'd0, 1'b0, W, W);
`endif

        // Second start during RUN must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd3;
        e0       = ecount + 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(e0, off, nb);
        chk("ign_offset", off, W);
        chk("ign_q", 32'(quotient), 32'd33);
        chk("ign_r", 32'(remainder), 32'd1);
        @(negedge clk);

        // Reset in the middle of a run.
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_q", 32'(quotient), 32'd0);
        chk("midrst_r", 32'(remainder), 32'd0);
        ndone = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("midrst_no_done", ndone, 0);
        do_op("post_rst_255_1", 8'd255, 8'd1, 8'hFF, 8'd0, 1'b0, W, W);

        // Back-to-back: start held through DONE, accepted in first IDLE cycle.
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom_range(1, 255));
        e0       = ecount + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            wait_done(e0, off, nb);
            chk("b2b_offset", off, W);
            if (k < 9) begin
                start    = 1'b1;
                dividend = W'($urandom);
                divisor  = W'($urandom_range(1, 255));
                e0       = ecount + 2;
                @(negedge clk);
                @(negedge clk);
                chk("b2b_accept_busy", 32'(busy), 32'd1);
                start = 1'b0;
            end
        end
        @(negedge clk);

        // Random traffic, including zero divisors and stray resets.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom);
            divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential radix-2 restoring divider, the inverse datapath to the team's Dadda multiplier on the Nexys4 DDR target. It accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock using a subtract-and-restore step, and signals completion with a one-cycle done pulse. It shares operand widths with the multiplier so the two can sit side by side behind the same board-level operand registers.

## Interface
- WIDTH, 8, operand, quotient and remainder width in bits (≥2)
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when state is IDLE
- dividend  input  WIDTH  numerator, sampled on the accepting edge
- divisor  input  WIDTH  denominator, sampled on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  high with done when the sampled divisor was 0; held with results

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 and divisor≠0 -> load operands, clear partial remainder, load iteration counter with WIDTH -> RUN. start=1 and divisor=0 -> DONE with quotient = all ones, remainder = dividend, div_by_zero=1.
- RUN, per edge: shift {partial remainder, dividend register} left 1; trial = partial remainder − divisor, computed at WIDTH+1 bits. If non-negative, keep trial and set the quotient LSB to 1. Otherwise restore and set it to 0. Decrement the counter. When the counter reaches its last iteration -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE.
- Results registers update only on entry to DONE. div_by_zero clears on the next accepted start.
- Unsigned arithmetic unless the Configuration macro is defined. Partial remainder is WIDTH+1 bits internally, so no overflow is possible for any operand pair.
- start while in RUN or DONE: ignored, not queued.
- rst (any state, including mid-RUN): next state IDLE. The in-flight operation is discarded.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE.
- Start accepted at edge t0: busy=1 from t0 to t0+WIDTH. Iterations occur on edges t0+1 … t0+WIDTH.
- done=1 and results valid in the cycle following edge t0+WIDTH, with busy=0 in that cycle.
- Latency from start edge to done visible: WIDTH cycles.
- Divide-by-zero: busy never asserts. done=1 in the cycle after edge t0 (latency 1).
- Earliest next accepted start: the edge that ends the DONE cycle is not accepted. Start is accepted from the following IDLE cycle, giving a throughput of one operation per WIDTH+2 cycles.

## Configuration
- DIV_SIGNED_EN defined: operands and results are two's complement.
  - Operand magnitudes are taken at load and signs are corrected at DONE entry, with no extra latency.
  - The quotient truncates toward zero, and the remainder takes the dividend's sign.
  - Most-negative ÷ −1 returns quotient = most-negative value (wrap) and remainder = 0.
  - Divide-by-zero returns quotient = −1 (all ones), remainder = dividend.
- DIV_SIGNED_EN undefined: purely unsigned. No sign logic is synthesized.

## Test plan
- WIDTH=8, unsigned: 200/7 -> quotient=28, remainder=4, done exactly 8 cycles after the start edge, busy high for 8 cycles.
- 255/1 -> 255 r 0. 3/250 -> 0 r 3. 0/9 -> 0 r 0. All have div_by_zero=0.
- 5/0 -> done in the cycle after the start edge, quotient=0xFF, remainder=5, div_by_zero=1, busy never high.
- Start 100/3, pulse start again with 50/5 at cycle 3 -> the second request is ignored and the result is 33 r 1. Then pulse rst at cycle 4 of a new run -> all outputs 0, no done pulse, and the next start behaves normally.
- With DIV_SIGNED_EN:
  - −7/2 -> quotient=0xFD (−3), remainder=0xFF (−1).
  - 7/−2 -> 0xFD r 1.
  - −128/−1 -> quotient=0x80, remainder=0.
- Back-to-back: start accepted in the first IDLE cycle after done, with 10 successive random operations -> every result matches the reference model.
